inta_sequencer: RTL

- Sequences the in-service register path of the 8259 core.
- Tracks the 8086-mode two-pulse INTA cycle and drives latch_in_service on the first pulse.
- Presents the interrupt vector on the second pulse.
- Decodes OCW2 commands into end_of_interrupt and priority_rotate, including automatic EOI and rotate-in-AEOI, so the in-service datapath never sees raw bus commands.

---
 rtl/pic_pkg.sv | 34 +++
 rtl/inta_sequencer_if.sv | 36 +++
 rtl/inta_sequencer_ocw2_decoder.sv | 55 +++++
 rtl/inta_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types, command encodings and index helpers for the 8259 INTA/ISR sequencing path.
package pic_pkg;

   localparam int NUM_IR = 8;
   localparam int VEC_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK1,
      ST_GAP,
      ST_ACK2
   } ack_state_e;

   // OCW2 command field {R, SL, EOI}
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_S_EOI        = 3'b011;
   localparam logic [2:0] OCW2_ROT_NS       = 3'b101;
   localparam logic [2:0] OCW2_ROT_S        = 3'b111;
   localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
   localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;

   function automatic logic [2:0] onehot_to_idx(input logic [NUM_IR-1:0] v);
      onehot_to_idx = 3'd0;
      for (int i = 0; i < NUM_IR; i++) begin
         if (v[i]) onehot_to_idx = 3'(i);
      end
   endfunction

   function automatic logic [NUM_IR-1:0] idx_to_onehot(input logic [2:0] idx);
      idx_to_onehot = NUM_IR'(1) << idx;
   endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Bus between the 8259 core and the INTA sequencer; slave is the sequencer side.
interface inta_sequencer_if;
   import pic_pkg::*;

   logic                 inta_n_i;
   logic [NUM_IR-1:0]    interrupt_i;
   logic [NUM_IR-1:0]    highest_level_in_service_i;
   logic [4:0]           vector_base_i;
   logic                 auto_eoi_i;
   logic                 ocw2_wr_i;
   logic [7:0]           ocw2_i;

   logic                 latch_in_service;
   logic [NUM_IR-1:0]    interrupt_o;
   logic [NUM_IR-1:0]    end_of_interrupt;
   logic [2:0]           priority_rotate;
   logic                 freeze;
   logic [VEC_W-1:0]     vector_o;
   logic                 vector_oe;
   logic                 ack_busy;

   modport master (
      output inta_n_i, interrupt_i, highest_level_in_service_i, vector_base_i,
             auto_eoi_i, ocw2_wr_i, ocw2_i,
      input  latch_in_service, interrupt_o, end_of_interrupt, priority_rotate,
             freeze, vector_o, vector_oe, ack_busy
   );

   modport slave (
      input  inta_n_i, interrupt_i, highest_level_in_service_i, vector_base_i,
             auto_eoi_i, ocw2_wr_i, ocw2_i,
      output latch_in_service, interrupt_o, end_of_interrupt, priority_rotate,
             freeze, vector_o, vector_oe, ack_busy
   );

endinterface

// File: rtl/inta_sequencer_ocw2_decoder.sv
// Combinational OCW2 decode into an EOI clear mask, a rotate update and AEOI-rotate set/clear.
module ocw2_decoder
   import pic_pkg::*;
(
   input  logic [7:0]        i_ocw2,
   input  logic [NUM_IR-1:0] i_highest,
   output logic [NUM_IR-1:0] o_eoi_mask,
   output logic              o_rotate_valid,
   output logic [2:0]        o_rotate_val,
   output logic              o_aeoi_rot_set,
   output logic              o_aeoi_rot_clr
);

   logic [2:0] w_cmd;
   logic [2:0] w_level;
   logic       w_is_ocw2;

   assign w_cmd     = i_ocw2[7:5];
   assign w_level   = i_ocw2[2:0];
   // A byte with D4 or D3 set is an ICW1/OCW3, never an OCW2.
   assign w_is_ocw2 = (i_ocw2[4:3] == 2'b00);

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      o_eoi_mask     = '0;
      o_rotate_valid = 1'b0;
      o_rotate_val   = 3'd0;
      o_aeoi_rot_set = 1'b0;
      o_aeoi_rot_clr = 1'b0;
      if (w_is_ocw2) begin
         unique case (w_cmd)
            OCW2_NS_EOI: o_eoi_mask = i_highest;
            OCW2_S_EOI:  o_eoi_mask = idx_to_onehot(w_level);
            OCW2_ROT_NS: begin
               o_eoi_mask     = i_highest;
               o_rotate_valid = |i_highest;
               o_rotate_val   = onehot_to_idx(i_highest);
            end
            OCW2_ROT_S: begin
               o_eoi_mask     = idx_to_onehot(w_level);
               o_rotate_valid = 1'b1;
               o_rotate_val   = w_level;
            end
            OCW2_SET_PRI: begin
               o_rotate_valid = 1'b1;
               o_rotate_val   = w_level;
            end
            OCW2_ROT_AEOI_SET: o_aeoi_rot_set = 1'b1;
            OCW2_ROT_AEOI_CLR: o_aeoi_rot_clr = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode two-pulse INTA sequencer: latches the ISR on pulse one, drives the vector on pulse two,
// and merges automatic and OCW2-commanded EOI / rotation into the in-service datapath controls.
module inta_sequencer
   import pic_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   inta_sequencer_if.slave  bus
);

   ack_state_e        r_state;
   ack_state_e        w_state_nxt;
   logic              r_inta_n_q;
   logic              w_fall;
   logic              w_rise;
   logic              w_start;
   logic              w_vec_start;
   logic              w_done;

   logic [NUM_IR-1:0] r_acked;
   logic              r_spurious;
   logic              r_auto_rotate;
   logic              r_latch;
   logic [NUM_IR-1:0] r_interrupt;
   logic [NUM_IR-1:0] r_eoi;
   logic [2:0]        r_rotate;
   logic              r_freeze;
   logic [VEC_W-1:0]  r_vector;
   logic              r_vector_oe;

   logic [NUM_IR-1:0] w_dec_eoi;
   logic              w_dec_rot_valid;
   logic [2:0]        w_dec_rot_val;
   logic              w_dec_aeoi_set;
   logic              w_dec_aeoi_clr;
   logic [NUM_IR-1:0] w_ocw_eoi;
   logic              w_ocw_rot_valid;
   logic              w_aeoi_fire;
   logic [NUM_IR-1:0] w_aeoi_eoi;
   logic              w_aeoi_rot_valid;
   logic              w_spur_cap;

   assign w_fall     =  r_inta_n_q & ~bus.inta_n_i;
   assign w_rise     = ~r_inta_n_q &  bus.inta_n_i;
   assign w_spur_cap = ~|bus.interrupt_i;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Falls arriving while a rise is expected, and rises in IDLE, fall through unhandled.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_vec_start = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         ST_IDLE: if (w_fall) begin
            w_state_nxt = ST_ACK1;
            w_start     = 1'b1;
         end
         ST_ACK1: if (w_rise) w_state_nxt = ST_GAP;
         ST_GAP: if (w_fall) begin
            w_state_nxt = ST_ACK2;
            w_vec_start = 1'b1;
         end
         ST_ACK2: if (w_rise) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   ocw2_decoder u_ocw2_decoder (
      .i_ocw2         (bus.ocw2_i),
      .i_highest      (bus.highest_level_in_service_i),
      .o_eoi_mask     (w_dec_eoi),
      .o_rotate_valid (w_dec_rot_valid),
      .o_rotate_val   (w_dec_rot_val),
      .o_aeoi_rot_set (w_dec_aeoi_set),
      .o_aeoi_rot_clr (w_dec_aeoi_clr)
   );

   assign w_ocw_eoi        = bus.ocw2_wr_i ? w_dec_eoi : '0;
   assign w_ocw_rot_valid  = bus.ocw2_wr_i & w_dec_rot_valid;
   assign w_aeoi_fire      = w_done & bus.auto_eoi_i & ~r_spurious;
   assign w_aeoi_eoi       = w_aeoi_fire ? r_acked : '0;
   assign w_aeoi_rot_valid = w_aeoi_fire & r_auto_rotate;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inta_n_q    <= 1'b1;
         r_acked       <= '0;
         r_spurious    <= 1'b0;
         r_auto_rotate <= 1'b0;
         r_latch       <= 1'b0;
         r_interrupt   <= '0;
         r_eoi         <= '0;
         r_rotate      <= 3'd7;
         r_freeze      <= 1'b0;
         r_vector      <= '0;
         r_vector_oe   <= 1'b0;
      end else begin
         r_inta_n_q <= bus.inta_n_i;
         r_latch    <= w_start & ~w_spur_cap;
         r_eoi      <= w_ocw_eoi | w_aeoi_eoi;

         if (w_start) begin
            r_acked     <= w_spur_cap ? NUM_IR'(8'h80) : bus.interrupt_i;
            r_spurious  <= w_spur_cap;
            r_interrupt <= bus.interrupt_i;
            r_freeze    <= 1'b1;
         end
         if (w_vec_start) begin
            r_vector    <= {bus.vector_base_i, onehot_to_idx(r_acked)};
            r_vector_oe <= 1'b1;
         end
         if (w_done) begin
            r_vector_oe <= 1'b0;
            r_freeze    <= 1'b0;
            r_interrupt <= '0;
         end

         // An explicit OCW2 rotation overrides the automatic one from the same cycle.
         if (w_ocw_rot_valid)       r_rotate <= w_dec_rot_val;
         else if (w_aeoi_rot_valid) r_rotate <= onehot_to_idx(r_acked);

         if (bus.ocw2_wr_i && w_dec_aeoi_set)      r_auto_rotate <= 1'b1;
         else if (bus.ocw2_wr_i && w_dec_aeoi_clr) r_auto_rotate <= 1'b0;
      end
   end

   assign bus.latch_in_service = r_latch;
   assign bus.interrupt_o      = r_interrupt;
   assign bus.end_of_interrupt = r_eoi;
   assign bus.priority_rotate  = r_rotate;
   assign bus.freeze           = r_freeze;
   assign bus.vector_o         = r_vector;
   assign bus.vector_oe        = r_vector_oe;
   assign bus.ack_busy         = (r_state != ST_IDLE);

endmodule
